seq_divider_32: RTL and testbench

Multi-cycle restoring divider for the UM ALU: one quotient bit per clock, 32 iterations, start/done handshake. It performs the inverse of the shift-add `multiplier_32` and replaces the combinational `fast_divider_32` on the `s = 2'b10` ALU path. The goal is to remove the wide combinational divide from the critical path. The ALU sequencer holds the instruction until `done`.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/full_adder_32.sv | 16 +
 rtl/seq_divider_32.sv | 116 +++++++++++
 tb/tb_seq_divider_32.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared ALU types and constants for the sequential divider path.
//   div_state_t       : divider FSM state encoding
//   DIV_W             : datapath width
//   DIV_ITERS         : quotient bits produced, one per clock
//   DIV_ZERO_QUOTIENT : quotient reported for a zero divisor
package alu_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned DIV_CNT_W = 5;

  localparam logic [DIV_W-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RUN  = 2'd1,
    D_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/full_adder_32.sv
// Purpose: 32-bit ripple-style adder with carry in/out.
//   x, y : addends
//   cin  : carry in
//   sum  : low 32 bits of x + y + cin
//   cout : carry out
module full_adder_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = 33'(x) + 33'(y) + 33'(cin);

endmodule

// File: rtl/seq_divider_32.sv
// Purpose: multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, r            : clock, synchronous active-high reset
//   start             : request, sampled only in IDLE
//   numerator         : dividend, captured on the accepting edge
//   denominator       : divisor, captured on the accepting edge
//   busy              : high whenever the FSM is not in IDLE
//   done              : one-cycle pulse, results valid in that cycle
//   quotient          : registered result, held until the next accepted start
//   remainder         : registered result, held until the next accepted start
//   div_by_zero       : registered flag, valid with done
module seq_divider_32
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic [DIV_W-1:0] numerator,
  input  logic [DIV_W-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0]     dvd_q;
  logic [DIV_W-1:0]     rem_q;
  logic [DIV_W-1:0]     den_q;

  logic [DIV_W-1:0]     trial;
  logic [DIV_W-1:0]     sub_sum;
  logic                 sub_cout;
  logic                 ge;
  logic [DIV_W-1:0]     rem_d;
  logic [DIV_W-1:0]     dvd_d;

  // Low 32 bits of the 33-bit trial value {rem, dividend msb}.
  assign trial = {rem_q[DIV_W-2:0], dvd_q[DIV_W-1]};

  // Trial subtraction: trial - den as trial + ~den + 1.
  full_adder_32 u_sub (
    .x    (trial),
    .y    (~den_q),
    .cin  (1'b1),
    .sum  (sub_sum),
    .cout (sub_cout)
  );

  // A set rem msb means the 33-bit trial exceeds any 32-bit divisor.
  assign ge    = rem_q[DIV_W-1] | sub_cout;
  assign rem_d = ge ? sub_sum : trial;
  assign dvd_d = {dvd_q[DIV_W-2:0], ge};

  // Divider FSM with registered handshake and results.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q     <= D_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        D_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (denominator == '0) begin
              quotient    <= DIV_ZERO_QUOTIENT;
              remainder   <= numerator;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_q     <= D_DONE;
            end else begin
              dvd_q   <= numerator;
              rem_q   <= '0;
              den_q   <= denominator;
              cnt_q   <= '0;
              state_q <= D_RUN;
            end
          end
        end
        D_RUN: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + DIV_CNT_W'(1);
          if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
            quotient    <= dvd_d;
            remainder   <= rem_d;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state_q     <= D_DONE;
          end
        end
        D_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= D_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        r;
  logic        start;
  logic [31:0] numerator;
  logic [31:0] denominator;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider_32 dut (
    .clk         (clk),
    .r           (r),
    .start       (start),
    .numerator   (numerator),
    .denominator (denominator),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] q;
    logic [31:0] rm;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one start pulse and wait (bounded) for done; returns results,
  // latency in cycles after the accepting edge and busy cycles seen.
  task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                        output logic [31:0] q, output logic [31:0] rm,
                        output logic dbz, output int lat, output int bcy);
    @(negedge clk);
    start = 1'b1; numerator = n; denominator = d;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcy = 0;
    while (done !== 1'b1 && lat < 64) begin
      if (busy) bcy++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcy++;
    q = quotient; rm = remainder; dbz = div_by_zero;
    @(negedge clk);
    chk("busy_low_after_done", 32'(busy), 32'd0);
  endtask

  // Wait for done with a cycle budget; lat counts from the current negedge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [31:0] q, rm;
  logic        dbz;
  int          lat, bcy, ndone;
  logic [31:0] rn, rd;

  initial begin
    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0};
    vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,  1'b1};
    vecs[4] = '{32'd7,          32'd9,          32'd0,          32'd7,  1'b0};
    vecs[5] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,  1'b0};
    vecs[6] = '{32'd1000,       32'd10,         32'd100,        32'd0,  1'b0};
    vecs[7] = '{32'd0,          32'd5,          32'd0,          32'd0,  1'b0};
    vecs[8] = '{32'd12345,      32'd123,        32'd100,        32'd45, 1'b0};
    vecs[9] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,  1'b1};

    r = 1'b1; start = 1'b0; numerator = '0; denominator = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    r = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].num, vecs[i].den, q, rm, dbz, lat, bcy);
      chk($sformatf("v%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), rm, vecs[i].rm);
      chk($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
      chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].dbz ? 32'd1 : 32'd33);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcy), vecs[i].dbz ? 32'd1 : 32'd33);
    end

    // Second start pulse during RUN is ignored.
    @(negedge clk);
    start = 1'b1; numerator = 32'd1000; denominator = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; numerator = 32'd9; denominator = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_quotient", quotient, 32'd100);
    chk("ign_remainder", remainder, 32'd0);
    @(negedge clk);
    chk("ign_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ign_no_requeue", 32'(busy), 32'd0);

    // Back-to-back with start held high; operands change mid-RUN.
    start = 1'b1; numerator = 32'd100; denominator = 32'd7;
    @(negedge clk);
    numerator = 32'd9; denominator = 32'd3;
    wait_done(lat);
    chk("b2b_first_latency", 32'(lat), 32'd33);
    chk("b2b_first_quotient", quotient, 32'd14);
    chk("b2b_first_remainder", remainder, 32'd2);
    @(negedge clk);
    chk("b2b_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("b2b_second_accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat);
    chk("b2b_second_latency", 32'(lat), 32'd33);
    chk("b2b_second_quotient", quotient, 32'd3);
    chk("b2b_second_remainder", remainder, 32'd0);
    @(negedge clk);

    // Reset mid-operation aborts without done.
    @(negedge clk);
    start = 1'b1; numerator = 32'd1000; denominator = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Reset wins over a simultaneous start.
    r = 1'b1; start = 1'b1; numerator = 32'd7; denominator = 32'd0;
    @(negedge clk);
    r = 1'b0; start = 1'b0;
    chk("rst_vs_start_busy", 32'(busy), 32'd0);
    chk("rst_vs_start_done", 32'(done), 32'd0);
    chk("rst_vs_start_dbz", 32'(div_by_zero), 32'd0);

    // Random nonzero divisors against the language operators.
    for (int i = 0; i < 200; i++) begin
      rn = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 1) == 1) rd = 32'($urandom_range(1, 1000));
      if (rd == 32'd0) rd = 32'd1;
      run_op(rn, rd, q, rm, dbz, lat, bcy);
      chk($sformatf("rnd%0d_q_%h_%h", i, rn, rd), q, rn / rd);
      chk($sformatf("rnd%0d_r_%h_%h", i, rn, rd), rm, rn % rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
